store_buffer: RTL and testbench

Write-buffering stage between the MEM-stage load/store control and the byte-addressed 64-bit data memory. Pipeline stores are queued in a small FIFO and retired to memory one doubleword per cycle whenever the memory port is idle. Loads get priority on the port and are served with store-to-load forwarding from the buffer. The block owns the memory's address, write-data, write-enable and read-enable inputs and consumes its combinational read data.

---
 rtl/store_buffer.sv | 136 +++++++++++++
 tb/tb_store_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between MEM-stage load/store control and a 64-bit byte-addressed data memory.
// Optional store-to-load forwarding is enabled by defining STORE_BUF_FWD_EN.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_stall,
  input  logic              drain_req,
  output logic              empty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic full;
  logic enq;
  logic deq;
  logic load_go;
  logic hit_exact;
  logic hit_overlap;
`ifdef STORE_BUF_FWD_EN
  logic [DATA_W-1:0] fwd_data;
`endif

  // True when the two doubleword accesses share at least one byte (includes equality).
  function automatic logic near(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    logic [ADDR_W-1:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return d < ADDR_W'(8);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full && !(drain_req && !empty);
  assign enq      = st_valid && st_ready && !drain_req;

  // Scan oldest to youngest so the last exact hit is the youngest; the incoming store is youngest.
  always_comb begin
    hit_exact   = 1'b0;
    hit_overlap = 1'b0;
`ifdef STORE_BUF_FWD_EN
    fwd_data    = '0;
`endif
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CNT_W'(i) < count_q) begin
        if (addr_q[head_q + PTR_W'(i)] == ld_addr) begin
          hit_exact = 1'b1;
`ifdef STORE_BUF_FWD_EN
          fwd_data  = data_q[head_q + PTR_W'(i)];
`endif
        end else if (near(addr_q[head_q + PTR_W'(i)], ld_addr)) begin
          hit_overlap = 1'b1;
        end
      end
    end
    if (enq) begin
      if (st_addr == ld_addr) begin
        hit_exact = 1'b1;
`ifdef STORE_BUF_FWD_EN
        fwd_data  = st_data;
`endif
      end else if (near(st_addr, ld_addr)) begin
        hit_overlap = 1'b1;
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign ld_stall = ld_req && hit_overlap;
  assign ld_data  = !ld_req ? '0 : (hit_exact ? fwd_data : mem_rdata);
`else
  assign ld_stall = ld_req && (hit_overlap || hit_exact);
  assign ld_data  = ld_req ? mem_rdata : '0;
`endif

  // Loads own the port; a stalled load leaves it free so the buffer keeps draining.
  assign load_go = ld_req && !ld_stall;
  assign deq     = !reset && !load_go && !empty;

  always_comb begin
    mem_read  = load_go;
    mem_write = deq;
    mem_addr  = '0;
    mem_wdata = '0;
    if (load_go) begin
      mem_addr = ld_addr;
    end else if (!empty) begin
      mem_addr  = addr_q[head_q];
      mem_wdata = data_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        addr_q[tail_q] <= st_addr;
        data_q[tail_q] <= st_data;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (deq) begin
        head_q <= head_q + PTR_W'(1);
      end
      if (enq && !deq) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!enq && deq) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model and a byte-array memory.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_req;
  logic [63:0] ld_addr;
  logic [63:0] ld_data;
  logic        ld_stall;
  logic        drain_req;
  logic        empty;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata;

  store_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(64),
    .DATA_W(64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_stall (ld_stall),
    .drain_req(drain_req),
    .empty    (empty),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment memory driven by the DUT's port; byte k starts out holding k.
  logic [7:0] mem [256];
  logic       mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (mem_write) begin
      for (int b = 0; b < 8; b++) mem[mem_addr[7:0] + 8'(b)] <= mem_wdata[8*b +: 8];
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < 8; b++) mem_rdata[8*b +: 8] = mem[mem_addr[7:0] + 8'(b)];
  end

  // Reference model: pending stores as a queue, memory image updated on modelled retirement.
  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;

  ent_t       q[$];
  logic [7:0] ref_mem [256];
  logic       m_enq = 1'b0;
  logic       m_deq = 1'b0;

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = ref_mem[a[7:0] + 8'(b)];
    return r;
  endfunction

  function automatic logic [63:0] absdiff(input logic [63:0] a, input logic [63:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  always @(posedge clk) begin : model_update
    if (mem_init) begin
      for (int k = 0; k < 256; k++) ref_mem[k] <= 8'(k);
    end
    if (reset) begin
      q.delete();
    end else begin
      if (m_deq) begin
        for (int b = 0; b < 8; b++) ref_mem[q[0].a[7:0] + 8'(b)] <= q[0].d[8*b +: 8];
        q.pop_front();
      end
      if (m_enq) q.push_back('{a: st_addr, d: st_data});
    end
  end

  always @(negedge clk) begin : compare
    ent_t        c[$];
    logic        ov, ex, stall_e, go, rdy_e;
    logic [63:0] fwd;
    int          n;
    if (reset) begin
      m_enq = 1'b0;
      m_deq = 1'b0;
      chk("reset_no_write", mem_write, 64'd0);
    end else begin
      n     = q.size();
      rdy_e = (n < int'(DEPTH)) && !(drain_req && n != 0);
      m_enq = st_valid && rdy_e && !drain_req;
      c = q;
      if (m_enq) c.push_back('{a: st_addr, d: st_data});
      ov  = 1'b0;
      ex  = 1'b0;
      fwd = '0;
      foreach (c[i]) begin
        if (c[i].a == ld_addr) begin
          ex  = 1'b1;
          fwd = c[i].d;
        end else if (absdiff(c[i].a, ld_addr) < 64'd8) begin
          ov = 1'b1;
        end
      end
`ifdef STORE_BUF_FWD_EN
      stall_e = ld_req && ov;
`else
      stall_e = ld_req && (ov || ex);
`endif
      go    = ld_req && !stall_e;
      m_deq = !go && n != 0;
      chk("empty", empty, 64'(n == 0));
      chk("st_ready", st_ready, 64'(rdy_e));
      chk("ld_stall", ld_stall, 64'(stall_e));
      chk("mem_read", mem_read, 64'(go));
      chk("mem_write", mem_write, 64'(m_deq));
      if (go) begin
        chk("mem_addr_load", mem_addr, ld_addr);
      end else if (m_deq) begin
        chk("mem_addr_drain", mem_addr, q[0].a);
        chk("mem_wdata_drain", mem_wdata, q[0].d);
      end
      if (!ld_req) begin
        chk("ld_data_idle", ld_data, 64'd0);
      end else if (go) begin
`ifdef STORE_BUF_FWD_EN
        chk("ld_data", ld_data, ex ? fwd : ref_rd(ld_addr));
`else
        chk("ld_data", ld_data, ref_rd(ld_addr));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic accepted;
    reset = 1'b1; mem_init = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_req = 1'b0; ld_addr = '0; drain_req = 1'b0;
    tick(); tick();
    reset = 1'b0; mem_init = 1'b0;
    #2;
    chk("rst_empty", empty, 64'd1);
    chk("rst_st_ready", st_ready, 64'd1);
    chk("rst_mem_write", mem_write, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_ld_data", ld_data, 64'd0);

    // Single store retires the cycle after acceptance.
    tick();
    st_valid = 1'b1; st_addr = 64'h08; st_data = 64'h11;
    #2; chk("s1_ready", st_ready, 64'd1);
    tick();
    st_valid = 1'b0;
    #2;
    chk("s1_write", mem_write, 64'd1);
    chk("s1_addr", mem_addr, 64'h08);
    chk("s1_wdata", mem_wdata, 64'h11);
    tick();
    #2; chk("s1_empty", empty, 64'd1);

    // Fill with a non-overlapping load holding the port.
    for (int i = 0; i < 4; i++) begin
      tick();
      st_valid = 1'b1; st_addr = 64'(8 * i); st_data = 64'h1000 + 64'(i);
      ld_req = 1'b1; ld_addr = 64'h80;
    end
    tick();
    st_addr = 64'h28; st_data = 64'h55;
    #2;
    chk("full_st_ready", st_ready, 64'd0);
    chk("load_mem_data", ld_data, 64'h8786858483828180);
    tick(); tick();
    ld_req = 1'b0;
    #2;
    chk("drain0_write", mem_write, 64'd1);
    chk("drain0_addr", mem_addr, 64'h00);
    accepted = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (st_ready) accepted = 1'b1;
      tick();
      if (accepted) break;
      #2;
    end
    st_valid = 1'b0;
    chk("fifth_accepted", 64'(accepted), 64'd1);
    for (int n = 0; n < 20 && !empty; n++) tick();
    #2; chk("fill_drained", empty, 64'd1);

    // Two stores to the same address, then a load to it.
    tick();
    st_valid = 1'b1; st_addr = 64'h20; st_data = 64'hAA; ld_req = 1'b1; ld_addr = 64'h80;
    tick();
    st_data = 64'hBB;
    tick();
    st_valid = 1'b0; ld_addr = 64'h20;
    #2;
`ifdef STORE_BUF_FWD_EN
    chk("fwd_stall", ld_stall, 64'd0);
    chk("fwd_data", ld_data, 64'hBB);
    chk("fwd_no_write", mem_write, 64'd0);
    tick();
    ld_req = 1'b0;
    tick(); tick();
    ld_req = 1'b1;
    #2;
`else
    chk("exact_stall0", ld_stall, 64'd1);
    chk("exact_wdata0", mem_wdata, 64'hAA);
    tick();
    #2;
    chk("exact_stall1", ld_stall, 64'd1);
    chk("exact_wdata1", mem_wdata, 64'hBB);
    tick();
    #2;
`endif
    chk("exact_final_stall", ld_stall, 64'd0);
    chk("exact_final_data", ld_data, 64'hBB);
    tick();
    ld_req = 1'b0;

    // Partial overlap stalls exactly one drain cycle.
    tick();
    st_valid = 1'b1; st_addr = 64'h10; st_data = 64'h0123456789ABCDEF;
    ld_req = 1'b1; ld_addr = 64'h80;
    tick();
    st_valid = 1'b0; ld_addr = 64'h14;
    #2;
    chk("ovl_stall", ld_stall, 64'd1);
    chk("ovl_write", mem_write, 64'd1);
    chk("ovl_addr", mem_addr, 64'h10);
    tick();
    #2;
    chk("ovl_release", ld_stall, 64'd0);
    chk("ovl_data", ld_data, 64'h0000100301234567);
    tick();
    ld_req = 1'b0;

    // Fence with three pending stores.
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 64'h40 + 64'(8 * i); st_data = 64'h4000 + 64'(i);
      ld_req = 1'b1; ld_addr = 64'h80;
      tick();
    end
    ld_req = 1'b0; drain_req = 1'b1; st_addr = 64'h58; st_data = 64'h77;
    #2;
    chk("fence_ready", st_ready, 64'd0);
    for (int n = 0; n < 10 && !empty; n++) begin
      tick();
      #2;
    end
    chk("fence_empty", empty, 64'd1);
    tick();
    #2; chk("fence_hold", empty, 64'd1);
    tick();
    drain_req = 1'b0;
    #2; chk("fence_release", st_ready, 64'd1);
    tick();
    st_valid = 1'b0;
    #2;
    chk("fence_enq", empty, 64'd0);
    chk("fence_write_addr", mem_addr, 64'h58);
    chk("fence_write_data", mem_wdata, 64'h77);
    tick();

    // Reset discards pending stores.
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 64'h60 + 64'(8 * i); st_data = 64'hDEAD0000 + 64'(i);
      ld_req = 1'b1; ld_addr = 64'h80;
      tick();
    end
    st_valid = 1'b0; ld_req = 1'b0; reset = 1'b1;
    #2; chk("midrst_no_write", mem_write, 64'd0);
    tick();
    reset = 1'b0;
    #2;
    chk("midrst_empty", empty, 64'd1);
    chk("midrst_write", mem_write, 64'd0);
    tick();
    ld_req = 1'b1; ld_addr = 64'h60;
    #2;
    chk("midrst_stall", ld_stall, 64'd0);
    chk("midrst_ld60", ld_data, 64'h6766656463626160);
    tick();
    ld_addr = 64'h68;
    #2; chk("midrst_ld68", ld_data, 64'h6F6E6D6C6B6A6968);
    tick();
    ld_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
